// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation is in flight at a time: IDLE grants, ISSUE lets the ALU settle, RESP holds the result.
module alu_req_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][WIDTH-1:0] req_opA,
  input  logic [1:0][WIDTH-1:0] req_opB,
  input  logic [1:0][2:0]       req_cmd,
  output logic [WIDTH-1:0]      alu_operandA,
  output logic [WIDTH-1:0]      alu_operandB,
  output logic [2:0]            alu_command,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_carryout,
  input  logic                  alu_zero,
  input  logic                  alu_overflow,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [WIDTH-1:0]      rsp_result,
  output logic [2:0]            rsp_flags,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t state_r;
  logic   last_grant_r;
  logic   owner_r;
  logic   grant_s;
  logic   fire_s;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // Round-robin pick: alternate on contention, otherwise whoever is asking.
  always_comb begin
    grant_s = 1'b0;
    if (req_valid == 2'b11) begin
      grant_s = ~last_grant_r;
    end else if (req_valid == 2'b10) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Ready only for the granted requester in IDLE; held low while reset is applied.
  always_comb begin
    req_ready = 2'b00;
    if (reset_n && (state_r == ST_IDLE) && req_valid[grant_s]) begin
      req_ready = onehot(grant_s);
    end else begin
      req_ready = 2'b00;
    end
  end

  assign fire_s = |(req_valid & req_ready);
  assign busy   = (state_r != ST_IDLE);

  // Control FSM with the registered ALU operands and captured response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      alu_operandA <= {WIDTH{1'b0}};
      alu_operandB <= {WIDTH{1'b0}};
      alu_command  <= 3'b000;
      rsp_result   <= {WIDTH{1'b0}};
      rsp_flags    <= 3'b000;
      rsp_valid    <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (fire_s) begin
            alu_operandA <= req_opA[grant_s];
            alu_operandB <= req_opB[grant_s];
            alu_command  <= req_cmd[grant_s];
            owner_r      <= grant_s;
            last_grant_r <= grant_s;
            state_r      <= ST_ISSUE;
          end else begin
            state_r      <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          rsp_result <= alu_result;
          rsp_flags  <= {alu_overflow, alu_zero, alu_carryout};
          rsp_valid  <= onehot(owner_r);
          state_r    <= ST_RESP;
        end
        ST_RESP: begin
          // Only the owner's ready completes the handshake.
          if (rsp_ready[owner_r]) begin
            rsp_valid <= 2'b00;
            state_r   <= ST_IDLE;
          end else begin
            state_r   <= ST_RESP;
          end
        end
        default: begin
          rsp_valid <= 2'b00;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
